// File: rtl/svc_rv_dmem_router.sv
// rtl/svc_rv_dmem_router.sv - dmem router: posted cache write buffer plus NUM_IO I/O channels
// Orders I/O behind buffered stores and stalls cache loads on read-after-write hazards.
module svc_rv_dmem_router #(
  parameter int NUM_IO     = 2,
  parameter int IO_SEL_LSB = 24,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               dmem_ren_i,
  input  logic [31:0]                        dmem_raddr_i,
  output logic [31:0]                        dmem_rdata_o,
  input  logic                               dmem_we_i,
  input  logic [31:0]                        dmem_waddr_i,
  input  logic [31:0]                        dmem_wdata_i,
  input  logic [3:0]                         dmem_wstrb_i,
  output logic                               dmem_stall_o,
  output logic                               cache_rd_valid_o,
  input  logic                               cache_rd_ready_i,
  output logic [31:0]                        cache_rd_addr_o,
  input  logic [31:0]                        cache_rd_data_i,
  input  logic                               cache_rd_data_valid_i,
  output logic                               cache_wr_valid_o,
  input  logic                               cache_wr_ready_i,
  output logic [31:0]                        cache_wr_addr_o,
  output logic [31:0]                        cache_wr_data_o,
  output logic [3:0]                         cache_wr_strb_o,
  output logic [NUM_IO-1:0]                  io_ren_o,
  output logic [NUM_IO-1:0]                  io_wen_o,
  output logic [31:0]                        io_raddr_o,
  output logic [31:0]                        io_waddr_o,
  output logic [31:0]                        io_wdata_o,
  output logic [3:0]                         io_wstrb_o,
  input  logic [NUM_IO*32-1:0]               io_rdata_i,
  output logic [$clog2(WBUF_DEPTH+1)-1:0]    wbuf_level_o
);
  localparam int IDX_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int LVL_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]      wb_addr_q [WBUF_DEPTH];
  logic [31:0]      wb_data_q [WBUF_DEPTH];
  logic [3:0]       wb_strb_q [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic [31:0]      rd_addr_q, rd_buf_q, rdata_q;
  logic             io_pend_q, io_pend_ok_q, st_done_q;
  logic [IDX_W-1:0] io_ch_q;

  logic             empty, full, pop, push, stall, hazard, we_eff, st_ok, st_now;
  logic             rd_start, io_rd, io_wr, wsel_ok, rsel_ok;
  logic [IDX_W-1:0] wsel, rsel;
  logic [PTR_W-1:0] off;
  logic [31:0]      io_val;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LVL_W'(WBUF_DEPTH));
  assign pop     = !empty && cache_wr_ready_i;
  assign wsel    = (NUM_IO > 1) ? dmem_waddr_i[IO_SEL_LSB +: IDX_W] : '0;
  assign rsel    = (NUM_IO > 1) ? dmem_raddr_i[IO_SEL_LSB +: IDX_W] : '0;
  assign wsel_ok = int'(wsel) < NUM_IO;
  assign rsel_ok = int'(rsel) < NUM_IO;
  // A store already handled while the CPU was stalled is still presented; ignore it.
  assign we_eff  = dmem_we_i && !st_done_q;
  assign st_ok   = dmem_waddr_i[31] ? empty : (!full || pop);

  always_comb begin
    hazard = we_eff && !dmem_waddr_i[31] && (dmem_waddr_i[31:2] == dmem_raddr_i[31:2]);
    off    = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ((LVL_W'(off) < count_q) && (wb_addr_q[i][31:2] == dmem_raddr_i[31:2])) hazard = 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    stall            = 1'b0;
    push             = 1'b0;
    io_wr            = 1'b0;
    io_rd            = 1'b0;
    st_now           = 1'b0;
    rd_start         = 1'b0;
    cache_rd_valid_o = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (we_eff && !st_ok) begin
            stall = 1'b1;
          end else begin
            if (we_eff) begin
              st_now = 1'b1;
              push   = !dmem_waddr_i[31];
              io_wr  = dmem_waddr_i[31] && wsel_ok;
            end
            if (dmem_ren_i && !dmem_raddr_i[31]) begin
              stall    = 1'b1;
              rd_start = 1'b1;
              state_d  = hazard ? DRAIN : RD_REQ;
            end else if (dmem_ren_i) begin
              if (empty && !push) io_rd = 1'b1;
              else                stall = 1'b1;
            end
          end
        end
        DRAIN: begin
          stall = 1'b1;
          if (empty) state_d = RD_REQ;
        end
        RD_REQ: begin
          stall            = 1'b1;
          cache_rd_valid_o = 1'b1;
          if (cache_rd_ready_i) state_d = RD_WAIT;
        end
        RD_WAIT: begin
          stall = 1'b1;
          if (cache_rd_data_valid_i) state_d = RD_DONE;
        end
        RD_DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    io_val = '0;
    for (int c = 0; c < NUM_IO; c++)
      if (io_pend_ok_q && (io_ch_q == IDX_W'(c))) io_val = io_rdata_i[c*32 +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_addr_q    <= '0;
      rd_buf_q     <= '0;
      rdata_q      <= '0;
      io_pend_q    <= 1'b0;
      io_pend_ok_q <= 1'b0;
      io_ch_q      <= '0;
      st_done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_q + LVL_W'(push) - LVL_W'(pop);
      st_done_q <= stall && (st_done_q || st_now);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (rd_start) rd_addr_q <= dmem_raddr_i;
      if (state_q == RD_WAIT && cache_rd_data_valid_i) rd_buf_q <= cache_rd_data_i;
      if (state_q == RD_DONE) rdata_q <= rd_buf_q;
      else if (io_pend_q)     rdata_q <= io_val;
      io_pend_q    <= io_rd;
      io_pend_ok_q <= rsel_ok;
      io_ch_q      <= rsel;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr_q[wr_ptr_q] <= dmem_waddr_i;
      wb_data_q[wr_ptr_q] <= dmem_wdata_i;
      wb_strb_q[wr_ptr_q] <= dmem_wstrb_i;
    end
  end

  always_comb begin
    io_ren_o = '0;
    io_wen_o = '0;
    if (io_rd && rsel_ok) io_ren_o = NUM_IO'(1) << rsel;
    if (io_wr)            io_wen_o = NUM_IO'(1) << wsel;
  end

  assign dmem_stall_o    = stall;
  assign dmem_rdata_o    = io_pend_q ? io_val : rdata_q;
  assign cache_rd_addr_o = rd_addr_q;
  assign cache_wr_valid_o = !empty;
  assign cache_wr_addr_o = empty ? '0 : wb_addr_q[rd_ptr_q];
  assign cache_wr_data_o = empty ? '0 : wb_data_q[rd_ptr_q];
  assign cache_wr_strb_o = empty ? '0 : wb_strb_q[rd_ptr_q];
  assign io_raddr_o      = io_rd ? dmem_raddr_i : '0;
  assign io_waddr_o      = io_wr ? dmem_waddr_i : '0;
  assign io_wdata_o      = io_wr ? dmem_wdata_i : '0;
  assign io_wstrb_o      = io_wr ? dmem_wstrb_i : '0;
  assign wbuf_level_o    = count_q;
endmodule

// File: tb/tb_svc_rv_dmem_router.sv
// tb/tb_svc_rv_dmem_router.sv - directed self-checking bench for svc_rv_dmem_router
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_svc_rv_dmem_router;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_ren, dmem_we, dmem_stall;
  logic [31:0] dmem_raddr, dmem_rdata, dmem_waddr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        cache_rd_valid, cache_rd_ready, cache_rd_data_valid;
  logic [31:0] cache_rd_addr, cache_rd_data;
  logic        cache_wr_valid, cache_wr_ready;
  logic [31:0] cache_wr_addr, cache_wr_data;
  logic [3:0]  cache_wr_strb;
  logic [1:0]  io_ren, io_wen;
  logic [31:0] io_raddr, io_waddr, io_wdata;
  logic [3:0]  io_wstrb;
  logic [63:0] io_rdata;
  logic [2:0]  wbuf_level;

  int          checks = 0;
  int          failures = 0;
  int          rd_hs = 0;
  int          rd_lat = 1;
  int          rd_cnt = 0;
  int          hs0, n;
  logic [31:0] rd_resp = '0;
  logic        hs_now, bad;

  always #5 clk = ~clk;

  svc_rv_dmem_router #(.NUM_IO(2), .IO_SEL_LSB(24), .WBUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dmem_ren_i(dmem_ren), .dmem_raddr_i(dmem_raddr), .dmem_rdata_o(dmem_rdata),
    .dmem_we_i(dmem_we), .dmem_waddr_i(dmem_waddr), .dmem_wdata_i(dmem_wdata),
    .dmem_wstrb_i(dmem_wstrb), .dmem_stall_o(dmem_stall),
    .cache_rd_valid_o(cache_rd_valid), .cache_rd_ready_i(cache_rd_ready),
    .cache_rd_addr_o(cache_rd_addr), .cache_rd_data_i(cache_rd_data),
    .cache_rd_data_valid_i(cache_rd_data_valid),
    .cache_wr_valid_o(cache_wr_valid), .cache_wr_ready_i(cache_wr_ready),
    .cache_wr_addr_o(cache_wr_addr), .cache_wr_data_o(cache_wr_data),
    .cache_wr_strb_o(cache_wr_strb),
    .io_ren_o(io_ren), .io_wen_o(io_wen), .io_raddr_o(io_raddr), .io_waddr_o(io_waddr),
    .io_wdata_o(io_wdata), .io_wstrb_o(io_wstrb), .io_rdata_i(io_rdata),
    .wbuf_level_o(wbuf_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    dmem_we = 1'b1; dmem_waddr = a; dmem_wdata = d; dmem_wstrb = 4'hF;
    settle();
    chk("store_nostall", dmem_stall, 0);
    step();
    dmem_we = 1'b0;
  endtask

  // Cache read model: data strobe rd_lat cycles after each accepted request.
  initial begin
    cache_rd_data_valid = 1'b0;
    cache_rd_data = '0;
    forever begin
      @(negedge clk);
      hs_now = cache_rd_valid && cache_rd_ready;
      @(posedge clk);
      #1;
      cache_rd_data_valid = 1'b0;
      if (rst) rd_cnt = 0;
      else if (hs_now) begin
        rd_hs++;
        rd_cnt = rd_lat;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          cache_rd_data_valid = 1'b1;
          cache_rd_data = rd_resp;
        end
      end
    end
  end

  initial begin
    dmem_ren = 0; dmem_raddr = '0; dmem_we = 0; dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    cache_rd_ready = 1'b1; cache_wr_ready = 1'b0; io_rdata = '0;
    repeat (3) step();
    settle();
    chk("rst_stall", dmem_stall, 0);
    chk("rst_level", wbuf_level, 0);
    chk("rst_wr_valid", cache_wr_valid, 0);
    chk("rst_rd_valid", cache_rd_valid, 0);
    chk("rst_rdata", dmem_rdata, 0);
    chk("rst_io", {io_ren, io_wen}, 0);
    rst = 1'b0;
    step();

    // 1: fill buffer, stall on 5th, then drain in order
    for (int i = 0; i < 4; i++) store(32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    dmem_we = 1'b1; dmem_waddr = 32'h110; dmem_wdata = 32'h1000_0004;
    settle();
    chk("t1_full_stall", dmem_stall, 1);
    chk("t1_level4", wbuf_level, 4);
    step(); settle();
    chk("t1_full_hold", dmem_stall, 1);
    cache_wr_ready = 1'b1;
    settle();
    chk("t1_pop_push_nostall", dmem_stall, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t1_drain_valid", cache_wr_valid, 1);
      chk("t1_drain_addr", cache_wr_addr, 32'h100 + 32'(4 * i));
      chk("t1_drain_data", cache_wr_data, 32'h1000_0000 + 32'(i));
      step();
      dmem_we = 1'b0;
      settle();
      if (i == 0) chk("t1_level_same", wbuf_level, 4);
    end
    chk("t1_level0", wbuf_level, 0);
    chk("t1_empty", cache_wr_valid, 0);

    // 2: read-after-write hazard drains before the cache read
    cache_wr_ready = 1'b0; rd_lat = 1; rd_resp = 32'hDEAD_BEEF; hs0 = rd_hs;
    store(32'h200, 32'hDEAD_BEEF);
    dmem_ren = 1'b1; dmem_raddr = 32'h200;
    settle();
    chk("t2_hazard_stall", dmem_stall, 1);
    chk("t2_no_rd_early", cache_rd_valid, 0);
    step(); settle();
    chk("t2_drain_stall", dmem_stall, 1);
    chk("t2_drain_no_rd", cache_rd_valid, 0);
    chk("t2_level1", wbuf_level, 1);
    cache_wr_ready = 1'b1; bad = 1'b0; n = 0;
    while (dmem_stall && n < 30) begin
      if (cache_rd_valid && wbuf_level != 0) bad = 1'b1;
      step(); settle(); n++;
    end
    chk("t2_stall_release", dmem_stall, 0);
    chk("t2_rd_before_empty", bad, 0);
    chk("t2_one_hs", rd_hs - hs0, 1);
    step(); dmem_ren = 1'b0; settle();
    chk("t2_rdata", dmem_rdata, 32'hDEAD_BEEF);

    // 3: slow cache load, stall held throughout
    rd_lat = 10; rd_resp = 32'h1234_5678; hs0 = rd_hs;
    dmem_ren = 1'b1; dmem_raddr = 32'h300;
    settle();
    chk("t3_stall", dmem_stall, 1);
    n = 0;
    while (dmem_stall && n < 40) begin step(); settle(); n++; end
    chk("t3_stall_release", dmem_stall, 0);
    chk("t3_stall_cycles", n, 13);
    chk("t3_one_hs", rd_hs - hs0, 1);
    step(); dmem_ren = 1'b0; settle();
    chk("t3_rdata", dmem_rdata, 32'h1234_5678);

    // 4: I/O load on channel 1
    io_rdata = {32'hA5A5_A5A5, 32'h5A5A_0000};
    dmem_ren = 1'b1; dmem_raddr = 32'h8100_0004;
    settle();
    chk("t4_io_ren", io_ren, 2'b10);
    chk("t4_nostall", dmem_stall, 0);
    chk("t4_io_raddr", io_raddr, 32'h8100_0004);
    step(); dmem_ren = 1'b0; settle();
    chk("t4_io_ren_pulse", io_ren, 0);
    chk("t4_rdata", dmem_rdata, 32'hA5A5_A5A5);
    step(); io_rdata = '0; settle();
    chk("t4_rdata_hold", dmem_rdata, 32'hA5A5_A5A5);

    // 5: I/O store ordered behind buffered stores
    cache_wr_ready = 1'b0;
    store(32'h400, 32'h4);
    store(32'h404, 32'h5);
    dmem_we = 1'b1; dmem_waddr = 32'h8000_0010; dmem_wdata = 32'hCAFE_F00D; dmem_wstrb = 4'h3;
    settle();
    chk("t5_stall", dmem_stall, 1);
    chk("t5_no_wen", io_wen, 0);
    step(); settle();
    chk("t5_stall_hold", dmem_stall, 1);
    cache_wr_ready = 1'b1; bad = 1'b0; n = 0;
    while (dmem_stall && n < 20) begin
      if (io_wen != 0) bad = 1'b1;
      step(); settle(); n++;
    end
    chk("t5_stall_release", dmem_stall, 0);
    chk("t5_wen_early", bad, 0);
    chk("t5_io_wen", io_wen, 2'b01);
    chk("t5_io_waddr", io_waddr, 32'h8000_0010);
    chk("t5_io_wdata", io_wdata, 32'hCAFE_F00D);
    chk("t5_io_wstrb", io_wstrb, 4'h3);
    chk("t5_level0", wbuf_level, 0);
    step(); dmem_we = 1'b0; settle();
    chk("t5_wen_pulse", io_wen, 0);

    // 6: reset in RD_WAIT with 3 buffered stores, then a normal load
    cache_wr_ready = 1'b0; rd_lat = 20;
    store(32'h500, 32'h1);
    store(32'h504, 32'h2);
    store(32'h508, 32'h3);
    dmem_ren = 1'b1; dmem_raddr = 32'h600;
    step(); step(); settle();
    chk("t6_level3", wbuf_level, 3);
    chk("t6_wait_stall", dmem_stall, 1);
    chk("t6_wait_no_rd", cache_rd_valid, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", dmem_stall, 0);
    chk("t6_rst_level", wbuf_level, 0);
    chk("t6_rst_wr_valid", cache_wr_valid, 0);
    chk("t6_rst_wr_addr", cache_wr_addr, 0);
    chk("t6_rst_rd_valid", cache_rd_valid, 0);
    chk("t6_rst_rd_addr", cache_rd_addr, 0);
    chk("t6_rst_rdata", dmem_rdata, 0);
    chk("t6_rst_io", {io_ren, io_wen}, 0);
    step();
    rst = 1'b0; dmem_ren = 1'b0;
    step();
    rd_lat = 2; rd_resp = 32'h0BAD_F00D; hs0 = rd_hs;
    dmem_ren = 1'b1; dmem_raddr = 32'h700;
    settle();
    chk("t6_new_stall", dmem_stall, 1);
    n = 0;
    while (dmem_stall && n < 40) begin step(); settle(); n++; end
    chk("t6_new_release", dmem_stall, 0);
    chk("t6_new_one_hs", rd_hs - hs0, 1);
    step(); dmem_ren = 1'b0; settle();
    chk("t6_new_rdata", dmem_rdata, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
